// File: rtl/seq_tx.sv
// Serial pattern transmitter: takes a parallel pattern over valid/ready and
// shifts it out LSB-first, with back-to-back frames, repeat mode and abort.
module seq_tx #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH) + 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data,
    input  logic [LW-1:0]    len,
    input  logic             loop,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             done
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_nx_s;
    logic [WIDTH-1:0] pattern_r, pattern_nx_s;
    logic [LW-1:0]    len_r, len_nx_s;
    logic             loop_r, loop_nx_s;
    logic [LW-1:0]    bit_cnt_r, bit_cnt_nx_s;
    logic             out_r, out_nx_s;
    logic             out_valid_r, out_valid_nx_s;
    logic             done_r, done_nx_s;
    logic [LW-1:0]    eff_len_s;
    logic             last_s;
    logic             in_ready_s;
    logic             take_s;

    // Clamp the requested length; 0 or anything above WIDTH means a full pattern.
    always_comb begin
        if ((len == LW'(0)) || (len > LW'(WIDTH))) begin
            eff_len_s = LW'(WIDTH);
        end else begin
            eff_len_s = len;
        end
    end

    // bit_cnt_r counts bits already placed on out, so the last bit is showing when it equals L.
    always_comb begin
        last_s     = (state_r == ST_SHIFT) && (bit_cnt_r == len_r);
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE:  in_ready_s = 1'b1;
            ST_SHIFT: in_ready_s = last_s && !loop_r;
            default:  in_ready_s = 1'b0;
        endcase
        take_s = in_valid && in_ready_s;
    end

    // Next-state and next-output logic; abort outranks every other SHIFT transition.
    always_comb begin
        state_nx_s     = state_r;
        pattern_nx_s   = pattern_r;
        len_nx_s       = len_r;
        loop_nx_s      = loop_r;
        bit_cnt_nx_s   = bit_cnt_r;
        out_nx_s       = 1'b0;
        out_valid_nx_s = 1'b0;
        done_nx_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_nx_s     = ST_SHIFT;
                    pattern_nx_s   = data;
                    len_nx_s       = eff_len_s;
                    loop_nx_s      = loop;
                    bit_cnt_nx_s   = LW'(1);
                    out_nx_s       = data[0];
                    out_valid_nx_s = 1'b1;
                    done_nx_s      = (eff_len_s == LW'(1)) && !loop;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_nx_s   = ST_IDLE;
                    bit_cnt_nx_s = LW'(0);
                end else if (last_s && loop_r) begin
                    bit_cnt_nx_s   = LW'(1);
                    out_nx_s       = pattern_r[0];
                    out_valid_nx_s = 1'b1;
                    done_nx_s      = 1'b0;
                end else if (last_s && take_s) begin
                    pattern_nx_s   = data;
                    len_nx_s       = eff_len_s;
                    loop_nx_s      = loop;
                    bit_cnt_nx_s   = LW'(1);
                    out_nx_s       = data[0];
                    out_valid_nx_s = 1'b1;
                    done_nx_s      = (eff_len_s == LW'(1)) && !loop;
                end else if (last_s) begin
                    state_nx_s   = ST_IDLE;
                    bit_cnt_nx_s = LW'(0);
                end else begin
                    bit_cnt_nx_s   = bit_cnt_r + LW'(1);
                    out_nx_s       = pattern_r[bit_cnt_r[IW-1:0]];
                    out_valid_nx_s = 1'b1;
                    done_nx_s      = (bit_cnt_r == (len_r - LW'(1))) && !loop_r;
                end
            end
            default: begin
                state_nx_s   = ST_IDLE;
                bit_cnt_nx_s = LW'(0);
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r     <= ST_IDLE;
            pattern_r   <= '0;
            len_r       <= '0;
            loop_r      <= 1'b0;
            bit_cnt_r   <= '0;
            out_r       <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            pattern_r   <= pattern_nx_s;
            len_r       <= len_nx_s;
            loop_r      <= loop_nx_s;
            bit_cnt_r   <= bit_cnt_nx_s;
            out_r       <= out_nx_s;
            out_valid_r <= out_valid_nx_s;
            done_r      <= done_nx_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign done      = done_r;

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: table-driven frames plus hand-written
// multi-cycle sequences (back-to-back, loop/abort, reset, detector chain).
module tb_seq_tx;

    logic       sys_clk;
    logic       sys_rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data;
    logic [3:0] len;
    logic       loop;
    logic       abort;
    logic       out;
    logic       out_valid;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    seq_tx #(.WIDTH(8)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .len       (len),
        .loop      (loop),
        .abort     (abort),
        .out       (out),
        .out_valid (out_valid),
        .done      (done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference "1011" sequence detector fed by the serial output, registered result.
    logic [3:0] hist_r;
    logic       det_r;
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hist_r <= 4'b0000;
            det_r  <= 1'b0;
        end else begin
            hist_r <= {hist_r[2:0], out};
            det_r  <= ({hist_r[2:0], out} == 4'b1011);
        end
    end

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [3:0] len;
        logic [7:0] exp_bits;
        int         exp_n;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cycle(input string name, input logic e_out, input logic e_valid,
                               input logic e_done, input logic e_ready);
        chk({name, "_out"},   32'(out),       32'(e_out));
        chk({name, "_valid"}, 32'(out_valid), 32'(e_valid));
        chk({name, "_done"},  32'(done),      32'(e_done));
        chk({name, "_ready"}, 32'(in_ready),  32'(e_ready));
    endtask

    task automatic run_frame(input vec_t v);
        chk({v.name, "_ready_idle"}, 32'(in_ready), 32'd1);
        data = v.data; len = v.len; loop = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; data = ~v.data; len = 4'd1; loop = 1'b1;
        for (int i = 0; i < v.exp_n; i++) begin
            check_cycle($sformatf("%s_b%0d", v.name, i), v.exp_bits[i], 1'b1,
                        i == v.exp_n - 1, i == v.exp_n - 1);
            tick();
        end
        loop = 1'b0;
        check_cycle({v.name, "_after"}, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic run_det(input logic [7:0] d, input int hit, input string name);
        data = d; len = 4'd8; loop = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s_det%0d", name, i), 32'(det_r), 32'(i == hit));
            tick();
        end
    endtask

    logic [15:0] b2b_bits;
    logic [7:0]  loop_bits;

    initial begin
        vecs[0] = '{"p6a",    8'b01101010, 4'd8,  8'b01101010, 8};
        vecs[1] = '{"len0",   8'h81,       4'd0,  8'h81,       8};
        vecs[2] = '{"len15",  8'h81,       4'd15, 8'h81,       8};
        vecs[3] = '{"len4",   8'h0F,       4'd4,  8'h0F,       4};
        vecs[4] = '{"len1",   8'hFF,       4'd1,  8'h01,       1};
        vecs[5] = '{"len2",   8'h02,       4'd2,  8'h02,       2};
        vecs[6] = '{"len9",   8'hA5,       4'd9,  8'hA5,       8};

        sys_rst = 1'b1; in_valid = 1'b0; data = 8'h00; len = 4'd0; loop = 1'b0; abort = 1'b0;
        tick(); tick();
        check_cycle("rst_held", 1'b0, 1'b0, 1'b0, 1'b1);
        sys_rst = 1'b0;
        tick();
        check_cycle("rst_rel", 1'b0, 1'b0, 1'b0, 1'b1);

        foreach (vecs[k]) run_frame(vecs[k]);

        // back-to-back A5 (8 bits) then 0F (4 bits), second offered on the last bit
        b2b_bits = 16'h0FA5;
        data = 8'hA5; len = 4'd8; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; data = 8'h0F; len = 4'd4;
        for (int i = 0; i < 12; i++) begin
            check_cycle($sformatf("b2b_b%0d", i), b2b_bits[i], 1'b1,
                        (i == 7) || (i == 11), (i == 7) || (i == 11));
            in_valid = (i == 7);
            tick();
        end
        in_valid = 1'b0;
        check_cycle("b2b_after", 1'b0, 1'b0, 1'b0, 1'b1);

        // back-to-back single-bit frames: one bit per cycle, done on each
        data = 8'h01; len = 4'd1; in_valid = 1'b1;
        tick();
        check_cycle("l1_a", 1'b1, 1'b1, 1'b1, 1'b1);
        data = 8'h00;
        tick();
        check_cycle("l1_b", 1'b0, 1'b1, 1'b1, 1'b1);
        data = 8'h01;
        tick();
        check_cycle("l1_c", 1'b1, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b0;
        tick();
        check_cycle("l1_after", 1'b0, 1'b0, 1'b0, 1'b1);

        // loop mode, abort on the 7th bit
        loop_bits = 8'b01011011;
        data = 8'b011; len = 4'd3; loop = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; loop = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check_cycle($sformatf("loop_b%0d", i), loop_bits[i], 1'b1, 1'b0, 1'b0);
            abort = (i == 6);
            tick();
        end
        abort = 1'b0;
        check_cycle("loop_abort", 1'b0, 1'b0, 1'b0, 1'b1);

        // abort in IDLE is ignored; the simultaneous handshake is taken
        abort = 1'b1; data = 8'h01; len = 4'd1; in_valid = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        check_cycle("idle_abort", 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check_cycle("idle_abort_after", 1'b0, 1'b0, 1'b0, 1'b1);

        // abort on a last bit beats a simultaneous handshake
        data = 8'h03; len = 4'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_cycle("ablast_b0", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_cycle("ablast_b1", 1'b1, 1'b1, 1'b1, 1'b1);
        abort = 1'b1; in_valid = 1'b1; data = 8'hFF; len = 4'd8;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        check_cycle("ablast_x", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_cycle("ablast_y", 1'b0, 1'b0, 1'b0, 1'b1);

        // asynchronous reset in the middle of a frame
        data = 8'hFF; len = 4'd8; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check_cycle("mrst_pre", 1'b1, 1'b1, 1'b0, 1'b0);
        #2 sys_rst = 1'b1;
        #1 check_cycle("mrst_now", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_cycle("mrst_held", 1'b0, 1'b0, 1'b0, 1'b1);
        sys_rst = 1'b0;
        tick();
        run_frame(vecs[1]);

        // chained into a 1011 detector: hit visible the cycle after bit 4, none for the corrupted pattern
        run_det(8'h1A, 5, "det_ok");
        run_det(8'h12, -1, "det_err");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
